// File: rtl/controle_multiciclo.sv
// Multicycle RV32I control unit.
// A Moore FSM sequences the shared datapath one instruction at a time. It
// stalls on the memory ready handshake, halts on unsupported opcodes and
// counts retired instructions.
module controle_multiciclo (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [6:0]  iOpcode,
    input  logic        iMemPronto,
    output logic        oEscreveIR,
    output logic        oEscrevePC,
    output logic        oEscrevePCCond,
    output logic        oOrigPC,
    output logic        oIouD,
    output logic        oLeMem,
    output logic        oEscreveMem,
    output logic        oEscreveReg,
    output logic [1:0]  oMem2Reg,
    output logic [1:0]  oOrigAULA,
    output logic [1:0]  oOrigBULA,
    output logic [1:0]  oALUOp,
    output logic [3:0]  oEstado,
    output logic        oErro,
    output logic [31:0] oInstrCont
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_LOAD  = 4'd5,
        WB_LOAD   = 4'd6,
        MEM_STORE = 4'd7,
        WB_ALU    = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10,
        JALR      = 4'd11,
        LUI       = 4'd12,
        ERRO      = 4'd15
    } estado_t;

    // RV32I major opcodes handled by this core
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operand A select
    localparam logic [1:0] A_PCANT = 2'b00;
    localparam logic [1:0] A_RS1   = 2'b01;
    localparam logic [1:0] A_PC    = 2'b10;
    localparam logic [1:0] A_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] B_RS2   = 2'b00;
    localparam logic [1:0] B_QUATRO = 2'b01;
    localparam logic [1:0] B_IMM   = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    // Write-back source select
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    estado_t     estado;
    estado_t     prox_estado;
    logic [31:0] instr_cont;

    // Moore outputs before the reset gating of enables/requests
    logic        escreve_ir_m;
    logic        escreve_pc_m;
    logic        escreve_pc_cond_m;
    logic        le_mem_m;
    logic        escreve_mem_m;
    logic        escreve_reg_m;
    logic        orig_pc_m;
    logic        iou_d_m;
    logic [1:0]  mem2reg_m;
    logic [1:0]  orig_a_m;
    logic [1:0]  orig_b_m;
    logic [1:0]  alu_op_m;
    logic        erro_m;

    // State register; reset lands in FETCH immediately
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            estado <= FETCH;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state logic: dispatch in DECODE, handshake waits in memory states
    always_comb begin
        prox_estado = estado;
        unique case (estado)
            FETCH: begin
                if (iMemPronto) prox_estado = DECODE;
            end
            DECODE: begin
                case (iOpcode)
                    OP_R:      prox_estado = EXEC_R;
                    OP_I:      prox_estado = EXEC_I;
                    OP_LOAD:   prox_estado = MEM_ADDR;
                    OP_STORE:  prox_estado = MEM_ADDR;
                    OP_BRANCH: prox_estado = BRANCH;
                    OP_JAL:    prox_estado = JAL;
                    OP_JALR:   prox_estado = JALR;
                    OP_LUI:    prox_estado = LUI;
                    default:   prox_estado = ERRO;
                endcase
            end
            EXEC_R:    prox_estado = WB_ALU;
            EXEC_I:    prox_estado = WB_ALU;
            LUI:       prox_estado = WB_ALU;
            WB_ALU:    prox_estado = FETCH;
            MEM_ADDR: begin
                if (iOpcode == OP_LOAD) prox_estado = MEM_LOAD;
                else                    prox_estado = MEM_STORE;
            end
            MEM_LOAD: begin
                if (iMemPronto) prox_estado = WB_LOAD;
            end
            WB_LOAD:   prox_estado = FETCH;
            MEM_STORE: begin
                if (iMemPronto) prox_estado = FETCH;
            end
            BRANCH:    prox_estado = FETCH;
            JAL:       prox_estado = FETCH;
            JALR:      prox_estado = FETCH;
            ERRO:      prox_estado = ERRO;
            default:   prox_estado = ERRO;
        endcase
    end

    // Per-state datapath controls; only FETCH looks at the ready input
    always_comb begin
        escreve_ir_m      = 1'b0;
        escreve_pc_m      = 1'b0;
        escreve_pc_cond_m = 1'b0;
        le_mem_m          = 1'b0;
        escreve_mem_m     = 1'b0;
        escreve_reg_m     = 1'b0;
        orig_pc_m         = 1'b0;
        iou_d_m           = 1'b0;
        mem2reg_m         = WB_ALUOUT;
        orig_a_m          = A_PCANT;
        orig_b_m          = B_RS2;
        alu_op_m          = ALU_ADD;
        erro_m            = 1'b0;
        unique case (estado)
            FETCH: begin
                // PC+4 is computed while the instruction is read; IR and PC
                // are only written once memory reports the data is valid.
                le_mem_m     = 1'b1;
                iou_d_m      = 1'b0;
                orig_a_m     = A_PC;
                orig_b_m     = B_QUATRO;
                alu_op_m     = ALU_ADD;
                escreve_ir_m = iMemPronto;
                escreve_pc_m = iMemPronto;
                orig_pc_m    = 1'b0;
            end
            DECODE: begin
                // Speculative PC+imm into ALUOut for branches and JAL
                orig_a_m = A_PCANT;
                orig_b_m = B_IMM;
                alu_op_m = ALU_ADD;
            end
            EXEC_R: begin
                orig_a_m = A_RS1;
                orig_b_m = B_RS2;
                alu_op_m = ALU_FUNCT;
            end
            EXEC_I: begin
                orig_a_m = A_RS1;
                orig_b_m = B_IMM;
                alu_op_m = ALU_FUNCT;
            end
            LUI: begin
                orig_a_m = A_ZERO;
                orig_b_m = B_IMM;
                alu_op_m = ALU_ADD;
            end
            WB_ALU: begin
                escreve_reg_m = 1'b1;
                mem2reg_m     = WB_ALUOUT;
            end
            MEM_ADDR: begin
                orig_a_m = A_RS1;
                orig_b_m = B_IMM;
                alu_op_m = ALU_ADD;
            end
            MEM_LOAD: begin
                le_mem_m = 1'b1;
                iou_d_m  = 1'b1;
            end
            WB_LOAD: begin
                escreve_reg_m = 1'b1;
                mem2reg_m     = WB_MDR;
            end
            MEM_STORE: begin
                escreve_mem_m = 1'b1;
                iou_d_m       = 1'b1;
            end
            BRANCH: begin
                orig_a_m          = A_RS1;
                orig_b_m          = B_RS2;
                alu_op_m          = ALU_BRANCH;
                escreve_pc_cond_m = 1'b1;
                orig_pc_m         = 1'b1;
            end
            JAL: begin
                escreve_pc_m  = 1'b1;
                orig_pc_m     = 1'b1;
                escreve_reg_m = 1'b1;
                mem2reg_m     = WB_PC4;
            end
            JALR: begin
                // Target LSB clearing happens in the datapath
                orig_a_m      = A_RS1;
                orig_b_m      = B_IMM;
                alu_op_m      = ALU_ADD;
                escreve_pc_m  = 1'b1;
                orig_pc_m     = 1'b0;
                escreve_reg_m = 1'b1;
                mem2reg_m     = WB_PC4;
            end
            ERRO: begin
                erro_m = 1'b1;
            end
            default: begin
                erro_m = 1'b1;
            end
        endcase
    end

    // Reset masks every write and request so an aborted instruction has no side effect
    always_comb begin
        oEscreveIR     = escreve_ir_m      & iRST;
        oEscrevePC     = escreve_pc_m      & iRST;
        oEscrevePCCond = escreve_pc_cond_m & iRST;
        oLeMem         = le_mem_m          & iRST;
        oEscreveMem    = escreve_mem_m     & iRST;
        oEscreveReg    = escreve_reg_m     & iRST;
        oOrigPC        = orig_pc_m;
        oIouD          = iou_d_m;
        oMem2Reg       = mem2reg_m;
        oOrigAULA      = orig_a_m;
        oOrigBULA      = orig_b_m;
        oALUOp         = alu_op_m;
        oErro          = erro_m;
    end

    // Retired-instruction counter: one count per return to FETCH, wraps naturally
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            instr_cont <= 32'd0;
        end else if ((prox_estado == FETCH) && (estado != FETCH)) begin
            instr_cont <= instr_cont + 32'd1;
        end
    end

    assign oEstado    = estado;
    assign oInstrCont = instr_cont;

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control unit for the team's RV32I processor. It sequences the shared datapath (PC, IR, register file, immediate generator, ALU, ALUOut/MDR registers, unified memory) one instruction at a time, driving every mux select and write enable from a Moore state machine. It stalls on a memory ready handshake and halts on an unsupported opcode.

## Interface
- No parameters.
- iCLK  in  1  system clock; all state changes on the rising edge
- iRST  in  1  asynchronous, active-low reset
- iOpcode  in  7  IR[6:0]; stable while IR is not being written
- iMemPronto  in  1  memory ready; completes the current read or write this cycle
- oEscreveIR  out  1  latch IR and old-PC register
- oEscrevePC  out  1  unconditional PC write
- oEscrevePCCond  out  1  PC write if the ALU branch condition is true
- oOrigPC  out  1  0 = ALU result, 1 = ALUOut
- oIouD  out  1  memory address: 0 = PC, 1 = ALUOut
- oLeMem  out  1  memory read request
- oEscreveMem  out  1  memory write request
- oEscreveReg  out  1  register file write
- oMem2Reg  out  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC+4
- oOrigAULA  out  2  ALU A: 00 = old PC, 01 = rs1, 10 = PC, 11 = zero
- oOrigBULA  out  2  ALU B: 00 = rs2, 01 = constant 4, 10 = immediate
- oALUOp  out  2  00 = add, 01 = branch compare, 10 = decode funct3/funct7
- oEstado  out  4  current state code
- oErro  out  1  halted on an illegal opcode
- oInstrCont  out  32  retired-instruction counter

## Operation
- State codes:
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_LOAD=5, WB_LOAD=6, MEM_STORE=7
  - WB_ALU=8, BRANCH=9, JAL=10, JALR=11, LUI=12, ERRO=15
- Any output not listed for a state is 0.
- FETCH: oLeMem=1, oIouD=0, A=10, B=01, add.
  - If iMemPronto=1: oEscreveIR=1, oEscrevePC=1, oOrigPC=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: A=00, B=10, add. ALUOut then holds PC+imm, the branch/JAL target. Dispatch on iOpcode:
  - 0110011 goes to EXEC_R.
  - 0010011 goes to EXEC_I.
  - 0000011 and 0100011 go to MEM_ADDR.
  - 1100011 goes to BRANCH.
  - 1101111 goes to JAL.
  - 1100111 goes to JALR.
  - 0110111 goes to LUI.
  - Anything else goes to ERRO.
- EXEC_R: A=01, B=00, ALUOp=10, then WB_ALU.
- EXEC_I: A=01, B=10, ALUOp=10, then WB_ALU.
- LUI: A=11, B=10, add, then WB_ALU.
- WB_ALU: oEscreveReg=1, oMem2Reg=00, then FETCH.
- MEM_ADDR: A=01, B=10, add. Goes to MEM_LOAD if iOpcode=0000011, else MEM_STORE.
- MEM_LOAD: oLeMem=1, oIouD=1. Waits for iMemPronto, then WB_LOAD.
- WB_LOAD: oEscreveReg=1, oMem2Reg=01, then FETCH.
- MEM_STORE: oEscreveMem=1, oIouD=1. Waits for iMemPronto, then FETCH.
- BRANCH: A=01, B=00, ALUOp=01, oEscrevePCCond=1, oOrigPC=1, then FETCH.
- JAL: oEscrevePC=1, oOrigPC=1, oEscreveReg=1, oMem2Reg=10, then FETCH.
- JALR: A=01, B=10, add, oEscrevePC=1, oOrigPC=0, oEscreveReg=1, oMem2Reg=10, then FETCH. Clearing the target LSB is done in the datapath.
- ERRO: oErro=1, all enables 0. Stays in ERRO until reset.
- oInstrCont increments by 1 on every transition into FETCH from a non-FETCH state. It wraps from 0xFFFFFFFF to 0.
- oEstado always equals the current state code.

## Timing
- Outputs are Moore functions of state. The only exception is the FETCH write enables, which are gated combinationally by iMemPronto.
- Reset:
  - Asserting iRST forces the state to FETCH and oInstrCont to 0 immediately.
  - While iRST=0, every write enable and request output is forced to 0.
  - Deassertion is asynchronous; the first fetch cycle is the first rising edge after it.
  - Reset in any state, including mid-wait or ERRO, aborts the instruction. No register, PC or memory write is issued.
- Cycle counts with iMemPronto held at 1:
  - R, I, LUI: 4
  - Load: 5
  - Store: 4
  - Branch, JAL, JALR: 3
- Each cycle with iMemPronto=0 in FETCH, MEM_LOAD or MEM_STORE adds one cycle. Requests stay asserted, with identical selects, until ready.
- iMemPronto is ignored in all other states.
- oLeMem and oEscreveMem are never asserted together.

## Test plan
- Reset, then release with iOpcode=0110011 and iMemPronto=1 -> states 0,1,2,8,0. oEscreveReg=1 only in state 8. oInstrCont=1 after 4 cycles.
- Load (0000011) with iMemPronto low for 2 cycles in MEM_LOAD -> states 0,1,4,5,5,5,6,0 (7 cycles). oIouD=1 and oLeMem=1 throughout 5.
- Store (0100011) -> states 0,1,4,7,0. oEscreveMem=1 only in 7. oEscreveReg never asserted.
- Branch then JAL then JALR back-to-back -> 3 cycles each. oMem2Reg=10 with oEscreveReg=1 in JAL and JALR. oInstrCont advances by 3.
- Illegal opcode 0000000 -> state 15, oErro=1, no enables. Remains there across 10 cycles. Reset returns to state 0 with oInstrCont=0.
- Reset asserted during MEM_STORE wait -> oEscreveMem drops asynchronously. State is 0 and the counter is cleared without waiting for the next clock edge.
